// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone IO arbiter.
// Holds the FSM state encoding, the owner encoding and the default timeout.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  function automatic logic [1:0] gnt_onehot(input arb_state_e st);
    logic [1:0] oh;
    case (st)
      ST_GNT0: oh = 2'b01;
      ST_GNT1: oh = 2'b10;
      default: oh = 2'b00;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog for the granted strobe: counts unanswered cycles, flags the
// threshold cycle and remembers the address of the last timed-out access.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        granted_i,
  input  logic        stb_i,
  input  logic        resp_i,
  input  logic [31:0] adr_i,
  output logic        tmo_o,
  output logic [31:0] tmo_adr_o
);

  localparam logic [15:0] THRESH = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [31:0] tmo_adr_q;
  logic [31:0] tmo_adr_d;
  logic        tmo_s;

  // A response on the threshold cycle wins, so it suppresses the timeout.
  assign tmo_s = granted_i && stb_i && !resp_i && (cnt_q == THRESH);

  // Next-state for the saturating counter and the captured address.
  always_comb begin
    cnt_d     = cnt_q;
    tmo_adr_d = tmo_adr_q;
    if (!granted_i || !stb_i || resp_i || tmo_s) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (tmo_s) begin
      tmo_adr_d = adr_i;
    end else begin
      tmo_adr_d = tmo_adr_q;
    end
  end

  // Counter and captured-address registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_q     <= 16'd0;
      tmo_adr_q <= 32'd0;
    end else begin
      cnt_q     <= cnt_d;
      tmo_adr_q <= tmo_adr_d;
    end
  end

  assign tmo_o     = tmo_s;
  assign tmo_adr_o = tmo_adr_q;

endmodule

// File: rtl/wb_io_arbiter.sv
// Round-robin, non-preemptive arbiter giving two Wishbone masters access to
// one IO bus, with zero-latency pass-through and a strobe watchdog.
module wb_io_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  input  logic [2:0]  wbm0_cti_i,
  input  logic [1:0]  wbm0_bte_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,
  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  input  logic [2:0]  wbm1_cti_i,
  input  logic [1:0]  wbm1_bte_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,
  output logic [31:0] wb_io_adr_o,
  output logic [31:0] wb_io_dat_o,
  output logic [3:0]  wb_io_sel_o,
  output logic        wb_io_we_o,
  output logic        wb_io_cyc_o,
  output logic        wb_io_stb_o,
  output logic [2:0]  wb_io_cti_o,
  output logic [1:0]  wb_io_bte_o,
  input  logic [31:0] wb_io_dat_i,
  input  logic        wb_io_ack_i,
  input  logic        wb_io_err_i,
  input  logic        wb_io_rty_i,
  output logic        tmo_o,
  output logic [31:0] tmo_adr_o,
  output logic [1:0]  gnt_o
);

  arb_state_e state_q;
  owner_e     last_gnt_q;
  logic       granted_s;
  logic       owner_stb_s;
  logic       resp_s;
  logic       tmo_s;

  // Grant FSM: ties go to the master that was not granted last.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= OWN_M1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wbm0_cyc_i && wbm1_cyc_i) begin
            if (last_gnt_q == OWN_M1) begin
              state_q    <= ST_GNT0;
              last_gnt_q <= OWN_M0;
            end else begin
              state_q    <= ST_GNT1;
              last_gnt_q <= OWN_M1;
            end
          end else if (wbm0_cyc_i) begin
            state_q    <= ST_GNT0;
            last_gnt_q <= OWN_M0;
          end else if (wbm1_cyc_i) begin
            state_q    <= ST_GNT1;
            last_gnt_q <= OWN_M1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GNT0: begin
          if (!wbm0_cyc_i) begin
            if (wbm1_cyc_i) begin
              state_q    <= ST_GNT1;
              last_gnt_q <= OWN_M1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            state_q <= ST_GNT0;
          end
        end
        ST_GNT1: begin
          if (!wbm1_cyc_i) begin
            if (wbm0_cyc_i) begin
              state_q    <= ST_GNT0;
              last_gnt_q <= OWN_M0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            state_q <= ST_GNT1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign granted_s   = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign owner_stb_s = ((state_q == ST_GNT0) && wbm0_stb_i) ||
                       ((state_q == ST_GNT1) && wbm1_stb_i);
  assign resp_s      = wb_io_ack_i || wb_io_err_i || wb_io_rty_i;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .granted_i (granted_s),
    .stb_i     (owner_stb_s),
    .resp_i    (resp_s),
    .adr_i     (wb_io_adr_o),
    .tmo_o     (tmo_s),
    .tmo_adr_o (tmo_adr_o)
  );

  // Forward the owner's request and route responses back to it alone.
  always_comb begin
    wb_io_adr_o = 32'd0;
    wb_io_dat_o = 32'd0;
    wb_io_sel_o = 4'd0;
    wb_io_we_o  = 1'b0;
    wb_io_cyc_o = 1'b0;
    wb_io_stb_o = 1'b0;
    wb_io_cti_o = 3'd0;
    wb_io_bte_o = 2'd0;
    wbm0_ack_o  = 1'b0;
    wbm0_err_o  = 1'b0;
    wbm0_rty_o  = 1'b0;
    wbm1_ack_o  = 1'b0;
    wbm1_err_o  = 1'b0;
    wbm1_rty_o  = 1'b0;
    case (state_q)
      ST_GNT0: begin
        wb_io_adr_o = wbm0_adr_i;
        wb_io_dat_o = wbm0_dat_i;
        wb_io_sel_o = wbm0_sel_i;
        wb_io_we_o  = wbm0_we_i;
        wb_io_cyc_o = wbm0_cyc_i;
        wb_io_stb_o = wbm0_stb_i && !tmo_s;
        wb_io_cti_o = wbm0_cti_i;
        wb_io_bte_o = wbm0_bte_i;
        wbm0_ack_o  = wb_io_ack_i;
        wbm0_err_o  = wb_io_err_i || tmo_s;
        wbm0_rty_o  = wb_io_rty_i;
      end
      ST_GNT1: begin
        wb_io_adr_o = wbm1_adr_i;
        wb_io_dat_o = wbm1_dat_i;
        wb_io_sel_o = wbm1_sel_i;
        wb_io_we_o  = wbm1_we_i;
        wb_io_cyc_o = wbm1_cyc_i;
        wb_io_stb_o = wbm1_stb_i && !tmo_s;
        wb_io_cti_o = wbm1_cti_i;
        wb_io_bte_o = wbm1_bte_i;
        wbm1_ack_o  = wb_io_ack_i;
        wbm1_err_o  = wb_io_err_i || tmo_s;
        wbm1_rty_o  = wb_io_rty_i;
      end
      default: begin
        wb_io_stb_o = 1'b0;
      end
    endcase
  end

  assign wbm0_dat_o = wb_io_dat_i;
  assign wbm1_dat_o = wb_io_dat_i;
  assign tmo_o      = tmo_s;
  assign gnt_o      = gnt_onehot(state_q);

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Directed bench for wb_io_arbiter: grant, round robin, handoff, timeout,
// response-at-threshold and asynchronous reset during a burst.
module tb_wb_io_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] io_adr, io_dat;
  logic [3:0]  io_sel;
  logic        io_we, io_cyc, io_stb;
  logic [2:0]  io_cti;
  logic [1:0]  io_bte;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;
  logic        tmo;
  logic [31:0] tmo_adr;
  logic [1:0]  gnt;

  int n_chk;
  int n_pass;

  wb_io_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_sel_i(m0_sel),
    .wbm0_we_i(m0_we), .wbm0_cyc_i(m0_cyc), .wbm0_stb_i(m0_stb),
    .wbm0_cti_i(m0_cti), .wbm0_bte_i(m0_bte),
    .wbm0_dat_o(m0_rdat), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty),
    .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_sel_i(m1_sel),
    .wbm1_we_i(m1_we), .wbm1_cyc_i(m1_cyc), .wbm1_stb_i(m1_stb),
    .wbm1_cti_i(m1_cti), .wbm1_bte_i(m1_bte),
    .wbm1_dat_o(m1_rdat), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty),
    .wb_io_adr_o(io_adr), .wb_io_dat_o(io_dat), .wb_io_sel_o(io_sel),
    .wb_io_we_o(io_we), .wb_io_cyc_o(io_cyc), .wb_io_stb_o(io_stb),
    .wb_io_cti_o(io_cti), .wb_io_bte_o(io_bte),
    .wb_io_dat_i(s_dat), .wb_io_ack_i(s_ack), .wb_io_err_i(s_err), .wb_io_rty_i(s_rty),
    .tmo_o(tmo), .tmo_adr_o(tmo_adr), .gnt_o(gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1;
    m0_adr = 32'd0; m0_dat = 32'd0; m0_sel = 4'd0; m0_we = 1'b0;
    m0_cyc = 1'b0;  m0_stb = 1'b0;  m0_cti = 3'd0; m0_bte = 2'd0;
    m1_adr = 32'd0; m1_dat = 32'd0; m1_sel = 4'd0; m1_we = 1'b0;
    m1_cyc = 1'b0;  m1_stb = 1'b0;  m1_cti = 3'd0; m1_bte = 2'd0;
    s_dat = 32'd0;  s_ack = 1'b0;   s_err = 1'b0;  s_rty = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_cyc", 32'(io_cyc), 32'h0);
    chk("rst_tmo", 32'(tmo), 32'h0);
    chk("rst_tmo_adr", tmo_adr, 32'h0);
    tick(); tick();
    rst = 1'b0;

    // Single request from m0; slave acks two cycles after the strobe.
    tick();
    m0_adr = 32'h0000_1040; m0_cyc = 1'b1; m0_stb = 1'b1; m0_sel = 4'hF;
    #1;
    chk("req_same_cycle_gnt", 32'(gnt), 32'h0);
    chk("req_same_cycle_cyc", 32'(io_cyc), 32'h0);
    tick();
    chk("single_gnt", 32'(gnt), 32'h1);
    chk("single_cyc", 32'(io_cyc), 32'h1);
    chk("single_stb", 32'(io_stb), 32'h1);
    chk("single_adr", io_adr, 32'h0000_1040);
    chk("single_sel", 32'(io_sel), 32'hF);
    tick(); tick();
    s_ack = 1'b1; s_dat = 32'hCAFE_0001;
    #1;
    chk("single_m0_ack", 32'(m0_ack), 32'h1);
    chk("single_m1_ack", 32'(m1_ack), 32'h0);
    chk("single_m0_dat", m0_rdat, 32'hCAFE_0001);
    chk("single_m1_dat", m1_rdat, 32'hCAFE_0001);
    tick();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("single_release", 32'(gnt), 32'h0);
    chk("idle_adr", io_adr, 32'h0);

    // Reset, then a tie: m0 first, direct handoff to m1, m0 wins next tie.
    rst = 1'b1; #1; rst = 1'b0;
    m0_adr = 32'h0000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h0000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
    m1_dat = 32'h5555_AAAA; m1_sel = 4'h3; m1_we = 1'b1;
    tick();
    chk("tie_gnt_m0", 32'(gnt), 32'h1);
    chk("tie_adr_m0", io_adr, 32'h0000_0100);
    s_ack = 1'b1;
    #1;
    chk("tie_m0_ack", 32'(m0_ack), 32'h1);
    chk("tie_m1_ack", 32'(m1_ack), 32'h0);
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("handoff_hold", 32'(gnt), 32'h1);
    tick();
    chk("handoff_gnt_m1", 32'(gnt), 32'h2);
    chk("handoff_adr", io_adr, 32'h0000_0200);
    chk("handoff_dat", io_dat, 32'h5555_AAAA);
    chk("handoff_sel", 32'(io_sel), 32'h3);
    chk("handoff_we", 32'(io_we), 32'h1);
    s_rty = 1'b1;
    #1;
    chk("m1_rty", 32'(m1_rty), 32'h1);
    chk("m0_rty", 32'(m0_rty), 32'h0);
    s_rty = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    chk("after_m1_idle", 32'(gnt), 32'h0);
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("tie2_gnt_m0", 32'(gnt), 32'h1);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Timeout: m1 reads 0x1800, no slave response; strike on the 8th cycle.
    m1_adr = 32'h0000_1800; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("tmo_gnt_m1", 32'(gnt), 32'h2);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tmo_early_%0d", i), {30'd0, tmo, m1_err}, 32'h0);
      tick();
    end
    chk("tmo_pulse", 32'(tmo), 32'h1);
    chk("tmo_m1_err", 32'(m1_err), 32'h1);
    chk("tmo_m0_err", 32'(m0_err), 32'h0);
    chk("tmo_stb_low", 32'(io_stb), 32'h0);
    tick();
    chk("tmo_adr", tmo_adr, 32'h0000_1800);
    chk("tmo_one_cycle", 32'(tmo), 32'h0);
    chk("tmo_stb_back", 32'(io_stb), 32'h1);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Ack exactly on the threshold cycle takes priority over the timeout.
    m0_adr = 32'h0000_2000; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    s_ack = 1'b1;
    #1;
    chk("thr_ack", 32'(m0_ack), 32'h1);
    chk("thr_err", 32'(m0_err), 32'h0);
    chk("thr_tmo", 32'(tmo), 32'h0);
    chk("thr_stb", 32'(io_stb), 32'h1);
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    chk("thr_tmo_adr_kept", tmo_adr, 32'h0000_1800);
    tick();

    // Reset in the middle of an incrementing burst from m0.
    m0_adr = 32'h0000_3000; m0_cti = 3'b010; m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("burst_cti", 32'(io_cti), 32'h2);
    s_ack = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_cyc", 32'(io_cyc), 32'h0);
    chk("rst_mid_stb", 32'(io_stb), 32'h0);
    chk("rst_mid_adr", io_adr, 32'h0);
    chk("rst_mid_cti", 32'(io_cti), 32'h0);
    chk("rst_mid_ack", 32'(m0_ack), 32'h0);
    chk("rst_mid_tmo_adr", tmo_adr, 32'h0);
    tick();
    rst = 1'b0; s_ack = 1'b0;
    #1;
    chk("post_rst_idle", 32'(gnt), 32'h0);
    tick();
    chk("post_rst_regrant", 32'(gnt), 32'h1);
    chk("post_rst_adr", io_adr, 32'h0000_3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_io_arbiter.md
WB_IO_ARBITER -- requirements
Module: wb_io_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, range 2..65535: cycles a granted strobe may wait for ack/err/rty before the arbiter terminates it.
REQ-002 Clock and reset SHALL be a single clock and an asynchronous active-high reset:
- wb_clk_i  input  1  clock; all state changes on its rising edge.
- wb_rst_i  input  1  reset; asynchronous, active-high.
REQ-003 Master n inputs, for n in {0,1}:
- wbm0_adr_i/wbm1_adr_i  input  32  address.
- wbm0_dat_i/wbm1_dat_i  input  32  write data.
- wbm0_sel_i/wbm1_sel_i  input  4  byte select.
- wbm0_we_i/wbm1_we_i  input  1  write enable.
- wbm0_cyc_i/wbm1_cyc_i  input  1  cycle; also the bus request.
- wbm0_stb_i/wbm1_stb_i  input  1  strobe.
- wbm0_cti_i/wbm1_cti_i  input  3  cycle type.
- wbm0_bte_i/wbm1_bte_i  input  2  burst type.
REQ-004 Master n outputs, for n in {0,1}:
- wbm0_dat_o/wbm1_dat_o  output  32  read data.
- wbm0_ack_o/wbm1_ack_o  output  1  acknowledge.
- wbm0_err_o/wbm1_err_o  output  1  error.
- wbm0_rty_o/wbm1_rty_o  output  1  retry.
REQ-005 Shared IO bus, towards the Wishbone IO interconnect master port:
- wb_io_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  output  32/32/4/1/1/1/3/2  forwarded master signals.
- wb_io_dat_i/ack_i/err_i/rty_i  input  32/1/1/1  slave responses.
REQ-006 Status outputs:
- tmo_o  output  1  one-cycle pulse on each timeout.
- tmo_adr_o  output  32  address of the most recent timed-out access.
- gnt_o  output  2  one-hot current owner; 00 = idle.

Function
REQ-007 States SHALL be IDLE, GNT0 and GNT1; register last_gnt records the last master granted.
REQ-008 In IDLE with exactly one wbmN_cyc_i high, the next state SHALL be GNTN.
REQ-009 In IDLE with both cyc high, the grant SHALL go to the master other than last_gnt (round robin).
REQ-010 In GNTN while wbmN_cyc_i stays high, the state SHALL hold; the other master is never preempted.
REQ-011 In GNTN when wbmN_cyc_i is low:
- other master's cyc high: next state is GNT(other), direct handoff, no idle cycle.
- otherwise: next state is IDLE.
REQ-012 Grant latency: a request in IDLE sees wb_io_cyc_o one cycle later; wb_io_cyc_o and wb_io_stb_o SHALL be low in IDLE.
REQ-013 In GNTN, the owner's adr/dat/sel/we/cyc/stb/cti/bte SHALL pass combinationally to wb_io_*_o, with zero added latency.
REQ-014 In GNTN, slave ack/err/rty SHALL route combinationally to master N only.
REQ-015 The non-owner's ack/err/rty SHALL be 0; both wbmN_dat_o SHALL equal wb_io_dat_i.
REQ-016 In IDLE, wb_io_adr_o/dat_o/sel_o/we_o/cti_o/bte_o SHALL be 0.
REQ-017 Timeout counter, 16 bits, saturating:
- clears when not granted, when owner stb is low, or when any of ack/err/rty is high.
- otherwise increments by 1 per cycle.
REQ-018 When the counter equals TIMEOUT_CYCLES-1 and no response arrives that cycle, the arbiter SHALL, in that same cycle:
- assert wbmN_err_o for the owner;
- force wb_io_stb_o low;
- pulse tmo_o.
REQ-019 On that timeout cycle, tmo_adr_o SHALL capture wbmN_adr_i, and the counter SHALL clear next cycle.
REQ-020 A slave response in the same cycle as the timeout threshold SHALL take priority: it is passed through, with no error and no tmo_o.
REQ-021 An owner dropping cyc in the same cycle as the other master raises it SHALL follow REQ-011, a handoff on the next edge.

Reset
REQ-022 While wb_rst_i is high, asynchronously:
- state = IDLE, last_gnt = 1 (master 0 wins first tie), counter = 0;
- tmo_o = 0, tmo_adr_o = 0, gnt_o = 00;
- all wb_io_*_o = 0, all wbmN_ack/err/rty_o = 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err to any master; after release the arbiter starts in IDLE.

Structure
REQ-024 Package wb_arb_pkg SHALL hold the state enumeration, the owner encoding and the default TIMEOUT_CYCLES constant.
REQ-025 Sub-module wb_arb_timeout SHALL contain the counter, the threshold compare and the tmo_adr_o capture register; the FSM and muxing stay in wb_io_arbiter.

Verification
REQ-026 Single request: m0 cyc/stb, adr 0x00001040, held at 1; slave acks 2 cycles after wb_io_stb_o.
- Required: gnt_o=01 one cycle after request, m0 ack, m1 ack=0.
REQ-027 Simultaneous request after reset: both cyc rise together.
- Required: m0 granted first; m0 drops cyc; GNT1 on the very next edge.
- Required: on the next tie, m0 wins again (last_gnt=1).
REQ-028 Timeout: TIMEOUT_CYCLES=8, m1 reads adr 0x00001800 with no slave response.
- Required: wbm1_err_o and tmo_o high exactly 8 cycles after stb is seen; tmo_adr_o=0x00001800; wb_io_stb_o low in that cycle.
REQ-029 Response at threshold: slave ack arrives exactly on cycle 8.
- Required: ack passed through, err=0, tmo_o=0.
REQ-030 Reset mid-burst: m0 burst with cti=010 in progress, wb_rst_i pulsed.
- Required: all outputs 0 asynchronously, state IDLE; m0 still requesting is re-granted one cycle after reset release.
